// File: rtl/playfield_engine.sv
`default_nettype none
// ============================================================================
// Module   : playfield_engine
// Purpose  : Playfield store and move arbiter. Holds a ROWS x COLS board of
//            colour codes (0 = empty), checks proposed piece moves one cell
//            per cycle, and answers each accepted request with exactly one of
//            commit / declined / steal. A colliding gravity step locks the
//            current piece into the board, removes full rows and reports how
//            many were removed.
// Ports    : clk, reset (sync, active-low)
//            req/intent/prop_x/prop_y/cur_x/cur_y/piece_color : move request
//            rd_x/rd_y -> rd_color : renderer read port with live overlay
//            ready/busy/commit/declined/steal/lines_cleared/top_out : status
// Revision : 1.0 - initial release
// ============================================================================
module playfield_engine #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int CELLS   = 4,
  parameter int CW      = 5,
  parameter int COLOR_W = 3,
  parameter int LCW     = $clog2(ROWS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  intent,
  input  logic [CELLS*CW-1:0]   prop_x,
  input  logic [CELLS*CW-1:0]   prop_y,
  input  logic [CELLS*CW-1:0]   cur_x,
  input  logic [CELLS*CW-1:0]   cur_y,
  input  logic [COLOR_W-1:0]    piece_color,
  input  logic [CW-1:0]         rd_x,
  input  logic [CW-1:0]         rd_y,
  output logic [COLOR_W-1:0]    rd_color,
  output logic                  ready,
  output logic                  busy,
  output logic                  commit,
  output logic                  declined,
  output logic                  steal,
  output logic [LCW-1:0]        lines_cleared,
  output logic                  top_out
);

  // Index widths. Row/column indices are taken from the low bits of a
  // CW-bit coordinate, so CW must be at least as wide as c_RIW and c_XIW.
  localparam int c_RIW = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int c_XIW = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int c_IIW = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [CW-1:0]    c_COLS      = CW'(COLS);
  localparam logic [CW-1:0]    c_ROWS      = CW'(ROWS);
  localparam logic [c_RIW-1:0] c_LAST_ROW  = c_RIW'(ROWS - 1);
  localparam logic [c_IIW-1:0] c_LAST_CELL = c_IIW'(CELLS - 1);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_CHECK = 3'd2,
    S_RESP  = 3'd3,
    S_LOCK  = 3'd4,
    S_SCAN  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [COLOR_W-1:0] r_board [ROWS][COLS];

  // r_row is shared: clear index in S_CLEAR, scan index in S_SCAN.
  logic [c_RIW-1:0]     r_row;
  logic [c_IIW-1:0]     r_cell;
  logic                 r_hit;
  logic                 r_intent;
  logic [CELLS*CW-1:0]  r_prop_x;
  logic [CELLS*CW-1:0]  r_prop_y;
  logic [CELLS*CW-1:0]  r_cur_x;
  logic [CELLS*CW-1:0]  r_cur_y;
  logic [COLOR_W-1:0]   r_color;
  logic [LCW-1:0]       r_count;

  logic [CW-1:0] w_px, w_py, w_lx, w_ly;
  logic          w_p_oob, w_l_oob, w_cell_hit;
  logic          w_row_full, w_row0_any, w_live_hit;

  // --------------------------------------------------------------------------
  // Cell selection for CHECK (latched proposal) and LOCK (latched current)
  // --------------------------------------------------------------------------
  always_comb begin
    w_px       = r_prop_x[int'(r_cell)*CW +: CW];
    w_py       = r_prop_y[int'(r_cell)*CW +: CW];
    w_lx       = r_cur_x[int'(r_cell)*CW +: CW];
    w_ly       = r_cur_y[int'(r_cell)*CW +: CW];
    w_p_oob    = (w_px >= c_COLS) || (w_py >= c_ROWS);
    w_l_oob    = (w_lx >= c_COLS) || (w_ly >= c_ROWS);
    w_cell_hit = w_p_oob;
    if (!w_p_oob && (r_board[w_py[c_RIW-1:0]][w_px[c_XIW-1:0]] != '0))
      w_cell_hit = 1'b1;
  end

  // Row status for the scan index and for row 0 (top_out).
  always_comb begin
    w_row_full = 1'b1;
    w_row0_any = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (r_board[r_row][c] == '0) w_row_full = 1'b0;
      if (r_board[0][c] != '0)     w_row0_any = 1'b1;
    end
  end

  // Live (not latched) piece overlay for the read port.
  always_comb begin
    w_live_hit = 1'b0;
    for (int i = 0; i < CELLS; i++)
      if ((cur_x[i*CW +: CW] == rd_x) && (cur_y[i*CW +: CW] == rd_y))
        w_live_hit = 1'b1;
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ready    = 1'b0;
    busy     = 1'b1;
    commit   = 1'b0;
    declined = 1'b0;
    steal    = 1'b0;
    case (r_state)
      S_CLEAR: if (r_row == c_LAST_ROW) w_next = S_IDLE;
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (req) w_next = S_CHECK;
      end
      S_CHECK: if (r_cell == c_LAST_CELL) w_next = S_RESP;
      S_RESP: begin
        if (!r_hit) begin
          commit = 1'b1;
          w_next = S_IDLE;
        end else if (r_intent) begin
          declined = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_next = S_LOCK;
        end
      end
      S_LOCK: if (r_cell == c_LAST_CELL) w_next = S_SCAN;
      // Row 0 is the last row looked at; leave only once it tests non-full.
      S_SCAN: if (!w_row_full && (r_row == '0)) w_next = S_DONE;
      S_DONE: begin
        steal  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and board
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_row         <= '0;
      r_cell        <= '0;
      r_hit         <= 1'b0;
      r_intent      <= 1'b0;
      r_prop_x      <= '0;
      r_prop_y      <= '0;
      r_cur_x       <= '0;
      r_cur_y       <= '0;
      r_color       <= '0;
      r_count       <= '0;
      lines_cleared <= '0;
      top_out       <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          for (int c = 0; c < COLS; c++) r_board[r_row][c] <= '0;
          r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + 1'b1;
        end
        S_IDLE: begin
          if (req) begin
            r_prop_x <= prop_x;
            r_prop_y <= prop_y;
            r_cur_x  <= cur_x;
            r_cur_y  <= cur_y;
            r_color  <= piece_color;
            r_intent <= intent;
            r_hit    <= 1'b0;
            r_cell   <= '0;
          end
        end
        S_CHECK: begin
          r_hit  <= r_hit | w_cell_hit;
          r_cell <= (r_cell == c_LAST_CELL) ? '0 : r_cell + 1'b1;
        end
        S_LOCK: begin
          if (!w_l_oob) r_board[w_ly[c_RIW-1:0]][w_lx[c_XIW-1:0]] <= r_color;
          r_cell <= (r_cell == c_LAST_CELL) ? '0 : r_cell + 1'b1;
          if (r_cell == c_LAST_CELL) begin
            r_row   <= c_LAST_ROW;
            r_count <= '0;
          end
        end
        S_SCAN: begin
          if (w_row_full) begin
            // Drop everything above the full row by one; the index stays
            // put so the row that just moved into place is re-tested.
            for (int r = ROWS - 1; r > 0; r--)
              if (r <= int'(r_row))
                for (int c = 0; c < COLS; c++) r_board[r][c] <= r_board[r-1][c];
            for (int c = 0; c < COLS; c++) r_board[0][c] <= '0;
            r_count <= r_count + 1'b1;
          end else if (r_row != '0) begin
            r_row <= r_row - 1'b1;
          end else begin
            // Board is final here, so the results line up with the steal pulse.
            lines_cleared <= r_count;
            top_out       <= w_row0_any;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Renderer read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset)
      rd_color <= '0;
    else if ((rd_x >= c_COLS) || (rd_y >= c_ROWS))
      rd_color <= '0;
    else if (w_live_hit)
      rd_color <= piece_color;
    else
      rd_color <= r_board[rd_y[c_RIW-1:0]][rd_x[c_XIW-1:0]];
  end

endmodule
`default_nettype wire

// File: tb/tb_playfield_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_playfield_engine
// Purpose  : Self-checking bench for playfield_engine. Keeps a plain 2-D
//            array model of the board and derives every expected response,
//            latency, row count and board image from the game rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_playfield_engine;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int CELLS   = 4;
  localparam int CW      = 5;
  localparam int COLOR_W = 3;
  localparam int LCW     = $clog2(ROWS + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req;
  logic                 intent;
  logic [CELLS*CW-1:0]  prop_x, prop_y, cur_x, cur_y;
  logic [COLOR_W-1:0]   piece_color;
  logic [CW-1:0]        rd_x, rd_y;
  logic [COLOR_W-1:0]   rd_color;
  logic                 ready, busy, commit, declined, steal, top_out;
  logic [LCW-1:0]       lines_cleared;

  int errors = 0;
  int checks = 0;
  int model [ROWS][COLS];
  int exp_lines = 0;

  always #5 clk = ~clk;

  playfield_engine #(
    .COLS(COLS), .ROWS(ROWS), .CELLS(CELLS), .CW(CW), .COLOR_W(COLOR_W), .LCW(LCW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .intent(intent),
    .prop_x(prop_x), .prop_y(prop_y), .cur_x(cur_x), .cur_y(cur_y),
    .piece_color(piece_color), .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color),
    .ready(ready), .busy(busy), .commit(commit), .declined(declined),
    .steal(steal), .lines_cleared(lines_cleared), .top_out(top_out)
  );

  function automatic logic [CELLS*CW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    logic [CELLS*CW-1:0] v;
    v[0*CW +: CW] = CW'(a0);
    v[1*CW +: CW] = CW'(a1);
    v[2*CW +: CW] = CW'(a2);
    v[3*CW +: CW] = CW'(a3);
    return v;
  endfunction

  function automatic bit model_hit(input logic [CELLS*CW-1:0] px, input logic [CELLS*CW-1:0] py);
    bit h = 0;
    for (int i = 0; i < CELLS; i++) begin
      int x = int'(px[i*CW +: CW]);
      int y = int'(py[i*CW +: CW]);
      if (x >= COLS || y >= ROWS) h = 1;
      else if (model[y][x] != 0) h = 1;
    end
    return h;
  endfunction

  // Lock the piece, then rebuild the board bottom-up from the rows that are
  // not full; removed rows leave empty rows at the top.
  task automatic model_lock(input logic [CELLS*CW-1:0] cx, input logic [CELLS*CW-1:0] cy,
                            input int col, output int n, output bit top);
    int nb [ROWS][COLS];
    int dst;
    bit full;
    for (int i = 0; i < CELLS; i++) begin
      int x = int'(cx[i*CW +: CW]);
      int y = int'(cy[i*CW +: CW]);
      if (x < COLS && y < ROWS) model[y][x] = col;
    end
    n = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1;
      for (int c = 0; c < COLS; c++) if (model[r][c] == 0) full = 0;
      if (full) n++;
      else begin
        for (int c = 0; c < COLS; c++) nb[dst][c] = model[r][c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--)
      for (int c = 0; c < COLS; c++) nb[r][c] = 0;
    model = nb;
    top = 0;
    for (int c = 0; c < COLS; c++) if (model[0][c] != 0) top = 1;
  endtask

  task automatic model_zero();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 0;
  endtask

  // Read the whole board through the read port with the live overlay parked
  // off-board, and compare against the model.
  task automatic check_board(input string nm);
    int bad = 0;
    int fx = 0, fy = 0;
    logic [COLOR_W-1:0] fgot = '0, fwant = '0;
    cur_x = '1;
    cur_y = '1;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        rd_x = CW'(x);
        rd_y = CW'(y);
        @(negedge clk);
        if (rd_color !== COLOR_W'(model[y][x])) begin
          if (bad == 0) begin fx = x; fy = y; fgot = rd_color; fwant = COLOR_W'(model[y][x]); end
          bad++;
        end
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s board: %0d cells differ, first (%0d,%0d) got %0d want %0d",
               nm, bad, fx, fy, fgot, fwant);
    end
  endtask

  // Issue one request and check response kind, latency and row results.
  task automatic do_move(input bit it, input logic [CELLS*CW-1:0] px, input logic [CELLS*CW-1:0] py,
                         input logic [CELLS*CW-1:0] cx, input logic [CELLS*CW-1:0] cy,
                         input int col, input string nm);
    bit hit;
    int n = 0;
    bit top = 0;
    int exp_lat;
    logic [2:0] exp_vec, got_vec;
    int lat = 0;
    int t = 0;
    hit = model_hit(px, py);
    if (!hit) begin exp_vec = 3'b100; exp_lat = CELLS + 1; end
    else if (it) begin exp_vec = 3'b010; exp_lat = CELLS + 1; end
    else begin
      model_lock(cx, cy, col, n, top);
      exp_vec = 3'b001;
      exp_lat = CELLS + 1 + CELLS + ROWS + n + 1;
    end
    while (ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: ready=%b after %0d cycles, want 1", nm, ready, t);
      return;
    end
    intent = it; prop_x = px; prop_y = py; cur_x = cx; cur_y = cy;
    piece_color = COLOR_W'(col);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    prop_x = CW*CELLS'($urandom);
    prop_y = CW*CELLS'($urandom);
    cur_x = '1; cur_y = '1;
    got_vec = 3'b000;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (commit || declined || steal) begin
        got_vec = {commit, declined, steal};
        lat = k;
        break;
      end
    end
    checks++;
    if (got_vec !== exp_vec) begin
      errors++;
      $display("FAIL %s response: {commit,declined,steal}=%b want %b", nm, got_vec, exp_vec);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
    end
    if (exp_vec == 3'b001) begin
      exp_lines = n;
      checks++;
      if (top_out !== top) begin
        errors++;
        $display("FAIL %s top_out: got %b want %b", nm, top_out, top);
      end
    end
    checks++;
    if (lines_cleared !== LCW'(exp_lines)) begin
      errors++;
      $display("FAIL %s lines_cleared: got %0d want %0d", nm, lines_cleared, exp_lines);
    end
    @(negedge clk);
    checks++;
    if ({commit, declined, steal} !== 3'b000 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_resp: pulses=%b ready=%b want 000/1", nm, {commit, declined, steal}, ready);
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || {commit, declined, steal, top_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b ready=%b pulses/top=%b want 1/0/0000",
               busy, ready, {commit, declined, steal, top_out});
    end
    checks++;
    if (rd_color !== '0 || lines_cleared !== '0) begin
      errors++;
      $display("FAIL reset_data: rd_color=%0d lines_cleared=%0d want 0/0", rd_color, lines_cleared);
    end
    reset = 1'b1;
    for (int i = 0; i < ROWS; i++) begin
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
        errors++;
        $display("FAIL clear_busy cycle %0d: busy=%b ready=%b want 1/0", i, busy, ready);
      end
      @(negedge clk);
    end
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: ready=%b busy=%b want 1/0", ready, busy);
    end
    model_zero();
    exp_lines = 0;
    check_board("after_clear");
    ok = 1;
  endtask

  task automatic test_commit();
    do_move(1'b0, pk(3,4,5,4), pk(5,5,5,6), pk(3,4,5,4), pk(4,4,4,5), 5, "commit_gravity");
    check_board("commit_unchanged");
    // Live overlay: matches the current inputs, not the latched copy.
    cur_x = pk(3,4,5,4); cur_y = pk(5,5,5,6); piece_color = 3'd5;
    rd_x = 5'd4; rd_y = 5'd6;
    @(negedge clk);
    checks++;
    if (rd_color !== 3'd5) begin
      errors++;
      $display("FAIL overlay_live: got %0d want 5", rd_color);
    end
    rd_x = 5'd10; rd_y = 5'd5;
    @(negedge clk);
    checks++;
    if (rd_color !== 3'd0) begin
      errors++;
      $display("FAIL read_oob_x: got %0d want 0", rd_color);
    end
    rd_x = 5'd3; rd_y = 5'd31;
    @(negedge clk);
    checks++;
    if (rd_color !== 3'd0) begin
      errors++;
      $display("FAIL read_oob_y: got %0d want 0", rd_color);
    end
  endtask

  task automatic test_decline();
    do_move(1'b1, pk(2,10,3,4), pk(0,0,1,1), pk(2,3,4,5), pk(0,0,0,0), 4, "decline_x10");
    check_board("decline_unchanged");
  endtask

  // Partial row 19 plus one row-18 cell, then a piece that completes row 19.
  task automatic test_clear1();
    do_move(1'b0, pk(0,0,0,0), pk(31,31,31,31), pk(0,1,2,3), pk(19,19,19,19), 1, "fill_a");
    do_move(1'b0, pk(0,0,0,0), pk(31,31,31,31), pk(4,5,9,0), pk(19,19,19,18), 2, "fill_b");
    do_move(1'b0, pk(6,7,8,7), pk(20,20,20,19), pk(6,7,8,7), pk(19,19,19,18), 3, "clear_one");
    checks++;
    if (lines_cleared !== LCW'(1)) begin
      errors++;
      $display("FAIL clear_one_count: got %0d want 1", lines_cleared);
    end
    cur_x = '1; cur_y = '1;
    rd_x = 5'd7; rd_y = 5'd19;
    @(negedge clk);
    checks++;
    if (rd_color !== 3'd3) begin
      errors++;
      $display("FAIL clear_one_shift(7,19): got %0d want 3", rd_color);
    end
    rd_x = 5'd0; rd_y = 5'd19;
    @(negedge clk);
    checks++;
    if (rd_color !== 3'd2) begin
      errors++;
      $display("FAIL clear_one_shift(0,19): got %0d want 2", rd_color);
    end
    check_board("clear_one_board");
  endtask

  task automatic test_reset_mid_scan();
    int pulses = 0;
    int t = 0;
    while (ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    intent = 1'b0; prop_x = pk(1,1,1,1); prop_y = pk(25,25,25,25);
    cur_x = pk(1,2,3,4); cur_y = pk(10,10,10,10); piece_color = 3'd6;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (commit || declined || steal) pulses++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (commit || declined || steal) pulses++;
    end
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || lines_cleared !== '0) begin
      errors++;
      $display("FAIL midscan_reset_state: busy=%b ready=%b lines=%0d want 1/0/0", busy, ready, lines_cleared);
    end
    reset = 1'b1;
    for (int k = 0; k < ROWS + 5; k++) begin
      @(negedge clk);
      if (commit || declined || steal) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midscan_no_pulse: got %0d pulses want 0", pulses);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL midscan_ready: got %b want 1", ready);
    end
    model_zero();
    exp_lines = 0;
    check_board("midscan_cleared");
  endtask

  task automatic test_clear2();
    for (int p = 0; p < 4; p++) begin
      int bx = (p % 2) * 4;
      int by = 18 + p / 2;
      do_move(1'b0, pk(0,0,0,0), pk(31,31,31,31), pk(bx, bx+1, bx+2, bx+3),
              pk(by, by, by, by), p + 1, "fill_two");
    end
    do_move(1'b0, pk(0,0,0,0), pk(31,31,31,31), pk(8,9,8,9), pk(18,18,19,19), 7, "clear_two");
    checks++;
    if (lines_cleared !== LCW'(2) || top_out !== 1'b0) begin
      errors++;
      $display("FAIL clear_two_result: lines=%0d top=%b want 2/0", lines_cleared, top_out);
    end
    check_board("clear_two_board");
  endtask

  task automatic test_req_held();
    int n_commit = 0, n_other = 0, commit_at = 0;
    int t = 0;
    while (ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    intent = 1'b1; prop_x = pk(2,3,4,5); prop_y = pk(7,7,7,7);
    cur_x = pk(2,3,4,5); cur_y = pk(6,6,6,6); piece_color = 3'd2;
    req = 1'b1;
    @(posedge clk);
    #1;
    prop_x = pk(31,31,31,31);   // would collide if it were re-sampled
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (commit) begin n_commit++; commit_at = k; end
      if (declined || steal) n_other++;
      if (k == CELLS + 1) req = 1'b0;
    end
    checks++;
    if (n_commit != 1 || n_other != 0 || commit_at != CELLS + 1) begin
      errors++;
      $display("FAIL req_held: commits=%0d others=%0d at=%0d want 1/0/%0d",
               n_commit, n_other, commit_at, CELLS + 1);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL req_held_idle: ready=%b want 1", ready);
    end
  endtask

  task automatic test_topout();
    do_move(1'b0, pk(0,0,0,0), pk(31,31,31,31), pk(0,1,0,1), pk(0,0,1,1), 4, "top_out");
    checks++;
    if (top_out !== 1'b1) begin
      errors++;
      $display("FAIL top_out_set: got %b want 1", top_out);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [CELLS*CW-1:0] px, py, cx, cy;
      for (int i = 0; i < CELLS; i++) begin
        px[i*CW +: CW] = CW'($urandom_range(0, COLS));
        py[i*CW +: CW] = CW'($urandom_range(10, ROWS));
        cx[i*CW +: CW] = CW'($urandom_range(0, COLS));
        cy[i*CW +: CW] = CW'($urandom_range(8, ROWS - 1));
      end
      do_move(1'($urandom_range(0, 1)), px, py, cx, cy, int'($urandom_range(1, 7)), "random");
    end
    check_board("random_board");
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; intent = 1'b0;
    prop_x = '0; prop_y = '0; cur_x = '1; cur_y = '1;
    piece_color = '0; rd_x = '0; rd_y = '0;
    test_reset();
    test_commit();
    test_decline();
    test_clear1();
    test_reset_mid_scan();
    test_clear2();
    test_req_held();
    test_topout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/playfield_engine.md
# playfield_engine

Parametrised playfield store and move arbiter for the tetris core. It holds the ROWS x COLS board of colour codes and checks each proposed piece move cell-by-cell against the board and its bounds. It answers every move with commit, decline or steal. On a gravity collision it locks the current piece into the board, clears full rows, and reports the number of rows removed. It sits between the game FSM (move requests, piece coordinates) and the VGA renderer (read port with live-piece overlay).

## Interface
- COLS, 10: board width in cells
- ROWS, 20: board height in cells; row 0 is the top row
- CELLS, 4: cells per piece
- CW, 5: coordinate width
- COLOR_W, 3: colour code width; code 0 means empty
- LCW, $clog2(ROWS+1): width of lines_cleared

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- req  in  1  move request; sampled only while ready=1
- intent  in  1  1 = user move, 0 = gravity step
- prop_x, prop_y  in  CELLS*CW each  proposed cell coordinates, packed; cell i at [i*CW +: CW]
- cur_x, cur_y  in  CELLS*CW each  current piece coordinates, packed
- piece_color  in  COLOR_W  colour of the current piece
- rd_x, rd_y  in  CW each  renderer read address
- rd_color  out  COLOR_W  registered read data
- ready  out  1  engine idle, will accept req
- busy  out  1  clear, check, lock or scan in progress
- commit  out  1  one-cycle pulse: move is legal
- declined  out  1  one-cycle pulse: user move collides
- steal  out  1  one-cycle pulse: piece locked, rows cleared
- lines_cleared  out  LCW  rows removed by the last lock; held until the next steal
- top_out  out  1  valid with steal: row 0 non-empty after clear

## Operation
- States: CLEAR, IDLE, CHECK, RESP, LOCK, SCAN, DONE.
- Reset low: state CLEAR, row index 0, and every output 0 except busy=1. lines_cleared=0 and rd_color=0.
- CLEAR: zeroes one row per cycle for ROWS cycles, then moves to IDLE.
- IDLE: ready=1, busy=0. If req=1, latch prop_*, cur_*, piece_color and intent, then go to CHECK. Later input changes do not affect the operation.
- CHECK: evaluates one cell per cycle, i = 0..CELLS-1. A cell hits if x>=COLS, y>=ROWS, or board[y][x]!=0. Hits are sticky ORed. After cell CELLS-1, go to RESP.
- RESP, outcome by hit and intent:
  - no hit: pulse commit, go to IDLE.
  - hit with intent=1: pulse declined, go to IDLE.
  - hit with intent=0: go to LOCK.
- LOCK: writes latched piece_color to latched cur cell i, one per cycle, CELLS cycles. Out-of-range cells are skipped. Occupied cells are overwritten.
- SCAN: index r starts at ROWS-1 and is checked each cycle.
  - Row r full (all COLS cells non-zero): shift rows 0..r-1 down one, zero row 0, increment count, keep r.
  - Otherwise: decrement r.
  - When row 0 has been checked non-full, go to DONE.
- DONE: pulse steal. Load lines_cleared with count and top_out with OR of row 0. Go to IDLE.
- req while ready=0 is ignored, not queued. The game FSM must hold or re-issue it.
- Duplicate cells in prop or cur are legal; a duplicate is checked or written twice.
- Read port: rd_color <= 0 if the address is out of range. Otherwise it is piece_color if (rd_x,rd_y) equals any live cur cell (not the latched copy), else board[rd_y][rd_x]. The read port is valid in every state.

## Timing
- req accepted at edge k; cell i checked in cycle k+1+i. commit or declined is high in cycle k+CELLS+1 (5 for CELLS=4). ready returns in cycle k+CELLS+2.
- Steal latency from acceptance: CELLS+1 (check) + CELLS (lock) + ROWS + lines cleared (scan) + 1. For CELLS=4, ROWS=20, no clear: 30 cycles. With one cleared row: 31.
- Exactly one of commit, declined or steal fires per accepted req.
- rd_color has 1-cycle latency from rd_x/rd_y.
- Reset low mid-operation aborts at the next edge; no response pulse. CLEAR takes ROWS cycles after reset is released.

## Test plan
- Release reset -> busy=1 for 20 cycles, then ready=1; every rd_color read gives 0.
- Gravity req with prop inside an empty board -> commit in cycle k+5, board unchanged.
- User req with prop_x=10 on any cell -> declined in cycle k+5, board unchanged, lines_cleared unchanged.
- Fill row 19 columns 0..5 and 10..? (use columns 0..5 and 9), then gravity lock with cur at (6,19),(7,19),(8,19),(7,18) and colour 3 -> steal, lines_cleared=1, old row 18 contents appear at row 19 with colour 3 at (7,19).
- Lock that fills rows 18 and 19 together -> lines_cleared=2, steal at cycle k+32, top_out=0.
- Assert reset low during SCAN -> no steal, board fully zero after CLEAR; req held high during CHECK is not accepted twice.
